// File: rtl/hazard_ctrl.sv
// Hazard detection, operand forwarding and pipeline sequencing for the 5-stage core.
// Owns every stage's rst/en, the ID forwarding selects, the taken-branch flush
// sequencer, the debug single-step gate and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned BR_FLUSH = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              id_is_store,
    input  logic              branch_taken,
    input  logic              exe_wen,
    input  logic              exe_is_load,
    input  logic [REG_AW-1:0] exe_waddr,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              mem_ready,
    input  logic              perf_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_m,
    output logic              if_rst,
    output logic              if_en,
    output logic              id_rst,
    output logic              id_en,
    output logic              exe_rst,
    output logic              exe_en,
    output logic              mem_rst,
    output logic              mem_en,
    output logic              wb_rst,
    output logic              wb_en,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Flush depth is clamped to what the 2-bit down-counter can express.
    localparam int unsigned BrDepth   = (BR_FLUSH > 3) ? 3 : BR_FLUSH;
    localparam bit          FwdOn     = (FWD_EN != 0);
    localparam bit          FlushOn   = (BrDepth != 0);
    localparam logic [1:0]  FlushLoad = FlushOn ? 2'(BrDepth - 1) : 2'd0;

    // Forwarding select encodings
    localparam logic [1:0] FwdRf     = 2'b00;
    localparam logic [1:0] FwdMemAlu = 2'b01;
    localparam logic [1:0] FwdMemLd  = 2'b10;
    localparam logic [1:0] FwdExeAlu = 2'b11;

    // Highest-priority sequencing rule active this cycle
    typedef enum logic [2:0] {
        RuleNone,
        RuleReset,
        RuleDebug,
        RuleMemWait,
        RuleStall,
        RuleFlush
    } rule_e;

    logic             debug_prev_q, debug_prev_d;
    logic [1:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic  exe_rs_match, exe_rt_match, mem_rs_match, mem_rt_match;
    logic  load_stall, raw_stall, step_rise, flushing;
    rule_e rule;

    // Source/writer match detection and the two stall conditions
    always_comb begin
        exe_rs_match = exe_wen && (exe_waddr != '0) && (exe_waddr == rs_addr) && rs_used;
        exe_rt_match = exe_wen && (exe_waddr != '0) && (exe_waddr == rt_addr) && rt_used;
        mem_rs_match = mem_wen && (mem_waddr != '0) && (mem_waddr == rs_addr) && rs_used;
        mem_rt_match = mem_wen && (mem_waddr != '0) && (mem_waddr == rt_addr) && rt_used;

        load_stall = 1'b0;
        raw_stall  = 1'b0;
        if (FwdOn) begin
            // A store only needs rt in MEM, where fwd_m supplies it, so no stall there.
            load_stall = exe_is_load && (exe_rs_match || (exe_rt_match && !id_is_store));
        end else begin
            raw_stall = exe_rs_match || exe_rt_match || mem_rs_match || mem_rt_match;
        end
    end

    // Forwarding selects; EXE is the youngest producer so it overrides MEM
    always_comb begin
        fwd_a = FwdRf;
        fwd_b = FwdRf;
        fwd_m = 1'b0;
        if (FwdOn && !rst) begin
            if (mem_rs_match) fwd_a = mem_is_load ? FwdMemLd : FwdMemAlu;
            if (mem_rt_match) fwd_b = mem_is_load ? FwdMemLd : FwdMemAlu;
            if (exe_rs_match) fwd_a = FwdExeAlu;
            if (exe_rt_match) fwd_b = FwdExeAlu;
            fwd_m = id_is_store && exe_rt_match && exe_is_load;
        end
    end

    // Priority rule selection
    always_comb begin
        step_rise = debug_step && !debug_prev_q;
        flushing  = (flush_left_q != 2'd0) || (branch_taken && FlushOn);
        if (rst) begin
            rule = RuleReset;
        end else if (debug_en && !step_rise) begin
            rule = RuleDebug;
        end else if (!mem_ready) begin
            rule = RuleMemWait;
        end else if (load_stall || raw_stall) begin
            rule = RuleStall;
        end else if (flushing) begin
            rule = RuleFlush;
        end else begin
            rule = RuleNone;
        end
    end

    // Stage enables and resets derived from the active rule
    always_comb begin
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        if_en   = 1'b1;
        id_en   = 1'b1;
        exe_en  = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
        unique case (rule)
            RuleReset: begin
                if_rst  = 1'b1;
                id_rst  = 1'b1;
                exe_rst = 1'b1;
                mem_rst = 1'b1;
                wb_rst  = 1'b1;
            end
            RuleDebug: begin
                if_en  = 1'b0;
                id_en  = 1'b0;
                exe_en = 1'b0;
                mem_en = 1'b0;
                wb_en  = 1'b0;
            end
            RuleMemWait: begin
                // Freeze IF..MEM; WB gets a bubble so the retiring op is not written twice.
                if_en  = 1'b0;
                id_en  = 1'b0;
                exe_en = 1'b0;
                mem_en = 1'b0;
                wb_rst = 1'b1;
            end
            RuleStall: begin
                if_en   = 1'b0;
                id_en   = 1'b0;
                exe_rst = 1'b1;
            end
            RuleFlush: begin
                id_rst = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next-state for flush sequencer, step edge detector and counters
    always_comb begin
        debug_prev_d = debug_step;
        flush_left_d = flush_left_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        // A new branch is accepted only when no flush is in progress.
        if ((rule == RuleFlush || rule == RuleNone) && flush_left_q == 2'd0 &&
            branch_taken && FlushOn) begin
            flush_left_d = FlushLoad;
        end else if (rule == RuleFlush && flush_left_q != 2'd0) begin
            flush_left_d = flush_left_q - 2'd1;
        end

        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((rule == RuleMemWait || rule == RuleStall) && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (rule == RuleFlush && flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end

        if (rst) begin
            debug_prev_d = 1'b0;
            flush_left_d = 2'd0;
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
        end
    end

    // State registers; reset is folded into the next-state logic above
    always_ff @(posedge clk) begin
        debug_prev_q <= debug_prev_d;
        flush_left_q <= flush_left_d;
        stall_cnt_q  <= stall_cnt_d;
        flush_cnt_q  <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance A forwards with a 2-deep branch flush,
// instance B stalls on RAW hazards and has no branch flush.
module tb_hazard_ctrl;

    localparam logic [9:0] CN = 10'b01_01_01_01_01; // normal
    localparam logic [9:0] CS = 10'b00_00_11_01_01; // hazard stall
    localparam logic [9:0] CW = 10'b00_00_00_00_11; // mem wait
    localparam logic [9:0] CD = 10'b00_00_00_00_00; // debug hold
    localparam logic [9:0] CF = 10'b01_11_01_01_01; // flush
    localparam logic [9:0] CR = 10'b11_11_11_11_11; // reset

    logic clk = 1'b0;
    logic rst, debug_en, debug_step;
    logic [4:0] rs_addr, rt_addr, exe_waddr, mem_waddr;
    logic rs_used, rt_used, id_is_store, branch_taken;
    logic exe_wen, exe_is_load, mem_wen, mem_is_load, mem_ready, perf_clr;

    logic [1:0] fwd_a_a, fwd_b_a, fwd_a_b, fwd_b_b;
    logic fwd_m_a, fwd_m_b;
    logic if_rst_a, if_en_a, id_rst_a, id_en_a, exe_rst_a, exe_en_a;
    logic mem_rst_a, mem_en_a, wb_rst_a, wb_en_a;
    logic if_rst_b, if_en_b, id_rst_b, id_en_b, exe_rst_b, exe_en_b;
    logic mem_rst_b, mem_en_b, wb_rst_b, wb_en_b;
    logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
    logic [9:0] ctl_a, ctl_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctl_a = {if_rst_a, if_en_a, id_rst_a, id_en_a, exe_rst_a, exe_en_a,
                    mem_rst_a, mem_en_a, wb_rst_a, wb_en_a};
    assign ctl_b = {if_rst_b, if_en_b, id_rst_b, id_en_b, exe_rst_b, exe_en_b,
                    mem_rst_b, mem_en_b, wb_rst_b, wb_en_b};

    hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_FLUSH(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .id_is_store(id_is_store), .branch_taken(branch_taken),
        .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr),
        .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .fwd_m(fwd_m_a),
        .if_rst(if_rst_a), .if_en(if_en_a), .id_rst(id_rst_a), .id_en(id_en_a),
        .exe_rst(exe_rst_a), .exe_en(exe_en_a), .mem_rst(mem_rst_a), .mem_en(mem_en_a),
        .wb_rst(wb_rst_a), .wb_en(wb_en_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_FLUSH(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .id_is_store(id_is_store), .branch_taken(branch_taken),
        .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_waddr(exe_waddr),
        .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .fwd_m(fwd_m_b),
        .if_rst(if_rst_b), .if_en(if_en_b), .id_rst(id_rst_b), .id_en(id_en_b),
        .exe_rst(exe_rst_b), .exe_en(exe_en_b), .mem_rst(mem_rst_b), .mem_en(mem_en_b),
        .wb_rst(wb_rst_b), .wb_en(wb_en_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       rs_u, rt_u, st;
        logic       ew, el;
        logic [4:0] ea;
        logic       mw, ml;
        logic [4:0] ma;
        logic       rdy, dbg;
        logic [1:0] fa, fb;
        logic       fm;
        logic [9:0] ca, cb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0;
        rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
        id_is_store = 1'b0; branch_taken = 1'b0;
        exe_wen = 1'b0; exe_is_load = 1'b0; exe_waddr = '0;
        mem_wen = 1'b0; mem_is_load = 1'b0; mem_waddr = '0;
        mem_ready = 1'b1; perf_clr = 1'b0;
    endtask

    // Leaves the bench at a negedge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        idle();
    endtask

    // EXE holds lw $4 and ID reads $4 on rs.
    task automatic load_use();
        exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = 5'd4;
        rs_addr = 5'd4; rs_used = 1'b1;
    endtask

    initial begin
        //          rs    rt    rsu rtu st ew el ea    mw ml ma    rdy dbg fa     fb     fm ca  cb
        vecs[0]  = '{5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 2'b00, 2'b00, 0, CN, CN};
        vecs[1]  = '{5'd3, 5'd3, 1, 1, 0, 1, 0, 5'd3, 0, 0, 5'd0, 1, 0, 2'b11, 2'b11, 0, CN, CS};
        vecs[2]  = '{5'd4, 5'd7, 1, 1, 0, 1, 1, 5'd4, 0, 0, 5'd0, 1, 0, 2'b11, 2'b00, 0, CS, CS};
        vecs[3]  = '{5'd2, 5'd5, 1, 1, 1, 1, 1, 5'd5, 0, 0, 5'd0, 1, 0, 2'b00, 2'b11, 1, CN, CS};
        vecs[4]  = '{5'd6, 5'd1, 1, 1, 0, 0, 0, 5'd0, 1, 0, 5'd6, 1, 0, 2'b01, 2'b00, 0, CN, CS};
        vecs[5]  = '{5'd1, 5'd6, 1, 1, 0, 0, 0, 5'd0, 1, 1, 5'd6, 1, 0, 2'b00, 2'b10, 0, CN, CS};
        vecs[6]  = '{5'd8, 5'd0, 1, 0, 0, 1, 0, 5'd8, 1, 0, 5'd8, 1, 0, 2'b11, 2'b00, 0, CN, CS};
        vecs[7]  = '{5'd0, 5'd0, 1, 1, 0, 1, 1, 5'd0, 1, 1, 5'd0, 1, 0, 2'b00, 2'b00, 0, CN, CN};
        vecs[8]  = '{5'd3, 5'd3, 0, 0, 0, 1, 1, 5'd3, 0, 0, 5'd0, 1, 0, 2'b00, 2'b00, 0, CN, CN};
        vecs[9]  = '{5'd3, 5'd0, 1, 0, 0, 0, 1, 5'd3, 0, 0, 5'd0, 1, 0, 2'b00, 2'b00, 0, CN, CN};
        vecs[10] = '{5'd4, 5'd7, 1, 1, 0, 1, 1, 5'd4, 0, 0, 5'd0, 0, 0, 2'b11, 2'b00, 0, CW, CW};
        vecs[11] = '{5'd4, 5'd7, 1, 1, 0, 1, 1, 5'd4, 0, 0, 5'd0, 1, 1, 2'b11, 2'b00, 0, CD, CD};
        vecs[12] = '{5'd9, 5'd9, 1, 1, 1, 0, 0, 5'd0, 1, 1, 5'd9, 1, 0, 2'b10, 2'b10, 0, CN, CS};

        idle();
        do_reset();

        // Combinational vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
            rs_used = vecs[i].rs_u; rt_used = vecs[i].rt_u; id_is_store = vecs[i].st;
            exe_wen = vecs[i].ew; exe_is_load = vecs[i].el; exe_waddr = vecs[i].ea;
            mem_wen = vecs[i].mw; mem_is_load = vecs[i].ml; mem_waddr = vecs[i].ma;
            mem_ready = vecs[i].rdy; debug_en = vecs[i].dbg;
            #1;
            chk($sformatf("v%0d fwd_a", i), 32'(fwd_a_a), 32'(vecs[i].fa));
            chk($sformatf("v%0d fwd_b", i), 32'(fwd_b_a), 32'(vecs[i].fb));
            chk($sformatf("v%0d fwd_m", i), 32'(fwd_m_a), 32'(vecs[i].fm));
            chk($sformatf("v%0d ctl_a", i), 32'(ctl_a), 32'(vecs[i].ca));
            chk($sformatf("v%0d ctl_b", i), 32'(ctl_b), 32'(vecs[i].cb));
            chk($sformatf("v%0d fwd_nofwd", i), 32'({fwd_a_b, fwd_b_b, fwd_m_b}), 32'd0);
        end

        // Load-use: one stall cycle, then forward load data from MEM; then perf_clr
        do_reset();
        chk("lu rst stall_cnt", 32'(stall_cnt_a), 32'd0);
        load_use();
        #1;
        chk("lu stall ctl", 32'(ctl_a), 32'(CS));
        @(negedge clk);
        idle();
        mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd4;
        rs_addr = 5'd4; rs_used = 1'b1;
        #1;
        chk("lu release ctl", 32'(ctl_a), 32'(CN));
        chk("lu fwd_a", 32'(fwd_a_a), 32'(2'b10));
        chk("lu stall_cnt", 32'(stall_cnt_a), 32'd1);
        @(negedge clk);
        idle();
        load_use();
        perf_clr = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("perf_clr stall_cnt", 32'(stall_cnt_a), 32'd0);

        // No forwarding: RAW stall while producer is in EXE then MEM
        do_reset();
        exe_wen = 1'b1; exe_waddr = 5'd6; rs_addr = 5'd6; rs_used = 1'b1;
        #1;
        chk("raw exe ctl", 32'(ctl_b), 32'(CS));
        @(negedge clk);
        idle();
        mem_wen = 1'b1; mem_waddr = 5'd6; rs_addr = 5'd6; rs_used = 1'b1;
        #1;
        chk("raw mem ctl", 32'(ctl_b), 32'(CS));
        chk("raw mem fwd", 32'(fwd_a_b), 32'd0);
        @(negedge clk);
        idle();
        rs_addr = 5'd6; rs_used = 1'b1;
        #1;
        chk("raw wb ctl", 32'(ctl_b), 32'(CN));
        chk("raw stall_cnt", 32'(stall_cnt_b), 32'd2);

        // Taken branch: 2 flush cycles on A, second pulse ignored; none on B
        do_reset();
        branch_taken = 1'b1;
        #1;
        chk("br c0 ctl_a", 32'(ctl_a), 32'(CF));
        chk("br c0 ctl_b", 32'(ctl_b), 32'(CN));
        @(negedge clk);
        #1;
        chk("br c1 ctl_a", 32'(ctl_a), 32'(CF));
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("br c2 ctl_a", 32'(ctl_a), 32'(CN));
        chk("br flush_cnt_a", 32'(flush_cnt_a), 32'd2);
        chk("br flush_cnt_b", 32'(flush_cnt_b), 32'd0);

        // Debug: hold, step rising edge advances one cycle, level does not
        do_reset();
        debug_en = 1'b1;
        #1;
        chk("dbg hold", 32'(ctl_a), 32'(CD));
        @(negedge clk);
        debug_step = 1'b1;
        #1;
        chk("dbg step", 32'(ctl_a), 32'(CN));
        @(negedge clk);
        #1;
        chk("dbg level", 32'(ctl_a), 32'(CD));

        // Mem wait over a load stall for 3 cycles, then stall re-evaluated, then reset
        do_reset();
        for (int c = 0; c < 3; c++) begin
            load_use();
            mem_ready = 1'b0;
            #1;
            chk($sformatf("mw c%0d ctl", c), 32'(ctl_a), 32'(CW));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("mw stall_cnt", 32'(stall_cnt_a), 32'd3);
        chk("mw release ctl", 32'(ctl_a), 32'(CS));
        @(negedge clk);
        branch_taken = 1'b1;
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst ctl_a", 32'(ctl_a), 32'(CR));
        chk("rst ctl_b", 32'(ctl_b), 32'(CR));
        chk("rst fwd", 32'({fwd_a_a, fwd_b_a, fwd_m_a}), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("rst stall_cnt", 32'(stall_cnt_a), 32'd0);
        chk("rst flush_cnt", 32'(flush_cnt_a), 32'd0);
        chk("rst post ctl", 32'(ctl_a), 32'(CN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard, forwarding and pipeline-sequencing unit for the 5-stage MIPS core. It generalises the single-cycle-memory controller with four additions: a stall-on-hazard mode with no forwarding, a multi-cycle data-memory wait handshake, a configurable taken-branch flush depth, and saturating performance counters. It sits beside the datapath and owns every stage's `*_rst`/`*_en` and the ID-stage forwarding selects. Instruction decode stays in the decoder; this block consumes decoded flags only.

## Interface
- `REG_AW`, 5: register address width.
- `FWD_EN`, 1: 1 = forward from EXE/MEM; 0 = stall until the producer reaches WB.
- `BR_FLUSH`, 1: ID bubbles inserted per taken branch (0 = delay-slot behaviour, max 3).
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: clock, single domain.
- `rst` in 1: synchronous reset, active-high.
- `debug_en`, `debug_step` in 1 each: suspend enable, and step pulse (rising edge advances one cycle).
- `rs_addr`, `rt_addr` in REG_AW: ID source registers.
- `rs_used`, `rt_used`, `id_is_store`, `branch_taken` in 1 each: ID flags (`branch_taken` means a resolved taken jump/branch in ID).
- `exe_wen`, `exe_is_load` in 1 each; `exe_waddr` in REG_AW: EXE writer.
- `mem_wen`, `mem_is_load` in 1 each; `mem_waddr` in REG_AW: MEM writer.
- `mem_ready` in 1: data memory done. Low means a MEM access is outstanding.
- `perf_clr` in 1: synchronous clear of the counters.
- `fwd_a`, `fwd_b` out 2: 00 regfile, 01 MEM ALU, 10 MEM load data, 11 EXE ALU.
- `fwd_m` out 1: forward the load result to the store data in MEM.
- `if_rst/if_en`, `id_rst/id_en`, `exe_rst/exe_en`, `mem_rst/mem_en`, `wb_rst/wb_en` out 1 each.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating cycle counters.

## Operation
- Hazard match: a writer matches a source when its `wen` is set, its waddr ≠ 0, its waddr equals the source address, and the source's `*_used` is set.
- Forwarding (FWD_EN=1):
  - MEM match gives 01, or 10 if `mem_is_load`.
  - EXE match overrides with 11.
  - `fwd_a`/`fwd_b` are 00 when FWD_EN=0.
- `fwd_m`=1 when all hold: `id_is_store`, an rt match against EXE, `exe_is_load`, and FWD_EN=1.
- load_stall (FWD_EN=1): an EXE match with `exe_is_load` on rs, or on rt while not `id_is_store`.
- raw_stall (FWD_EN=0): any EXE or MEM match on rs or rt.
- Stage control defaults: all `*_en`=1 and all `*_rst`=0. Apply the first matching rule below (priority order).
- Rule 1, `rst`: all `*_rst`=1; the flush counter, debug edge register and perf counters clear.
- Rule 2, debug hold (`debug_en` and no step rising edge): all `*_en`=0.
- Rule 3, mem wait (`mem_ready`=0): IF/ID/EXE/MEM `en`=0; `wb_rst`=1 inserts a WB bubble.
- Rule 4, load_stall or raw_stall: `if_en`=`id_en`=0; `exe_rst`=1.
- Rule 5, flushing (`flush_left`≠0, or `branch_taken` with BR_FLUSH≥1): `id_rst`=1.
- Flush state `flush_left` (2 bits):
  - Loads BR_FLUSH−1 in a cycle where `branch_taken` is accepted with `flush_left`=0 under rule 5 or no rule.
  - Otherwise decrements when `id_rst` is flush-driven.
  - Holds under rules 2–4.
  - `branch_taken` is ignored while `flush_left`≠0.
- Counters:
  - `stall_cnt` increments in cycles under rule 3 or 4.
  - `flush_cnt` increments in cycles under rule 5.
  - Both saturate at all-ones.
  - `perf_clr` zeroes both and wins over increment.
  - Neither counts under rule 1 or 2.

## Timing
- Forward selects and stage controls are combinational from the current inputs and registered state; zero-cycle latency.
- Registered state updates on `posedge clk`: `debug_prev`, `flush_left`, counters.
- Reset values: `flush_left`=0, `debug_prev`=0, counters 0. During `rst`, outputs are fwd 00, `fwd_m`=0, all `*_rst`=1, all `*_en`=1.
- A load-use stall lasts exactly 1 cycle with FWD_EN=1.
- With FWD_EN=0 a RAW stall lasts up to 2 cycles (producer in EXE) and releases when the producer enters WB.
- A mem wait of N cycles freezes for N cycles. A hazard coincident with mem wait is re-evaluated after release.
- Taken branch: `id_rst` asserts for BR_FLUSH consecutive unstalled cycles, starting the branch's cycle.
- `rst` mid-flush or mid-stall aborts immediately.

## Test plan
- `add $3` in EXE (exe_wen=1, waddr=3), ID reads rs=3, rt=3, FWD_EN=1 -> `fwd_a`=`fwd_b`=11, no stall, `exe_rst`=0.
- `lw $4` in EXE, ID `add` with rs=4 -> one cycle with `if_en`=`id_en`=0 and `exe_rst`=1. Next cycle, with the load now in MEM, `fwd_a`=10. `stall_cnt`=1.
- `lw $5` in EXE, ID `sw` with rt=5 and rs≠5 -> `fwd_m`=1, no stall.
- FWD_EN=0: `add $6` in EXE, ID reads $6 -> 2 stall cycles (producer in EXE, then MEM), release when it reaches WB; fwd always 00.
- BR_FLUSH=2, `branch_taken` pulse -> `id_rst`=1 for 2 cycles and `flush_cnt`=2. A second `branch_taken` during the flush is ignored. With BR_FLUSH=0 there is no flush.
- `mem_ready` low 3 cycles during a load_stall -> the mem wait wins: IF–MEM `en`=0 and `wb_rst`=1 for 3 cycles, and `stall_cnt`=3. Then `rst` mid-sequence -> all `*_rst`=1 and counters 0 next cycle.
